// File: rtl/arb_grant_lock.sv
// rtl/arb_grant_lock.sv - locks a one-hot arbiter grant into a multi-cycle ownership grant
module arb_grant_lock #(
  parameter int NUM_PORTS = 4,
  parameter int MAX_HOLD  = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NUM_PORTS-1:0]         req_i,
  input  logic [NUM_PORTS-1:0]         arb_gnt_i,
  input  logic [NUM_PORTS-1:0]         done_i,
  output logic [NUM_PORTS-1:0]         gnt_o,
  output logic [$clog2(NUM_PORTS)-1:0] owner_o,
  output logic                         busy_o,
  output logic                         timeout_o
);

  localparam int IDX_W = $clog2(NUM_PORTS);
  localparam int CNT_W = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam logic [CNT_W-1:0] CNT_SAT   = '1;

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  state_e               state_q, state_d;
  logic [NUM_PORTS-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0]     owner_q, owner_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 tmo_q, tmo_d;

  logic [NUM_PORTS-1:0] masked, lowest;
  logic                 capture;
  logic                 rel_done, rel_req, rel_hold;

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_PORTS-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

  // A grant for a port that is not requesting is never taken; duplicates collapse to the lowest bit
  always_comb begin
    masked   = arb_gnt_i & req_i;
    lowest   = masked & (~masked + NUM_PORTS'(1));
    capture  = |masked;
    rel_done = |(done_i & gnt_q);
    rel_req  = ~|(req_i & gnt_q);
    rel_hold = (MAX_HOLD != 0) && (cnt_q == HOLD_LAST);
  end

  // State and owner registers; reset drops ownership without waiting for a clock
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      owner_q <= '0;
      cnt_q   <= '0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  // Next-state: capture from IDLE or GAP, release from GRANT on done, request drop or hold limit
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE, GAP: begin
        tmo_d = 1'b0;
        if (capture) begin
          state_d = GRANT;
          gnt_d   = lowest;
          owner_d = onehot_idx(lowest);
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      GRANT: begin
        if (cnt_q != CNT_SAT) cnt_d = cnt_q + CNT_W'(1);
        if (rel_done || rel_req || rel_hold) begin
          state_d = GAP;
          gnt_d   = '0;
          tmo_d   = rel_hold && !rel_done && !rel_req;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        tmo_d   = 1'b0;
      end
    endcase
  end

  // Outputs decode registered state only, so no input reaches an output combinationally
  always_comb begin
    busy_o    = (state_q == GRANT);
    gnt_o     = busy_o ? gnt_q : '0;
    owner_o   = busy_o ? owner_q : '0;
    timeout_o = (state_q == GAP) && tmo_q;
  end

endmodule

// File: tb/tb_arb_grant_lock.sv
// tb/tb_arb_grant_lock.sv - directed self-checking bench for arb_grant_lock
module tb_arb_grant_lock;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req, arb, done;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       busy, tmo;

  int checks = 0;
  int errors = 0;

  arb_grant_lock #(.NUM_PORTS(4), .MAX_HOLD(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .arb_gnt_i(arb), .done_i(done),
    .gnt_o(gnt), .owner_o(owner), .busy_o(busy), .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; arb = '0; done = '0;
    #12;
    check("rst_gnt", gnt, 4'b0000);
    check("rst_busy", busy, 0);
    check("rst_tmo", tmo, 0);
    check("rst_owner", owner, 0);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("idle_gnt", {busy, tmo, gnt}, 6'b0);
    end

    // single owner released by done on its third GRANT cycle
    req = 4'b0100; arb = 4'b0100;
    tick();
    check("one_gnt1", gnt, 4'b0100);
    check("one_own1", owner, 2);
    check("one_busy", busy, 1);
    tick();
    check("one_gnt2", gnt, 4'b0100);
    tick();
    check("one_gnt3", gnt, 4'b0100);
    done = 4'b0100;
    tick();
    check("one_gap", {busy, gnt}, 5'b0);
    check("one_tmo", tmo, 0);
    req = '0; arb = '0; done = '0;
    tick();
    check("one_idle", {busy, tmo, gnt}, 6'b0);

    // handover from port 0 to port 1 through one GAP cycle
    req = 4'b0011; arb = 4'b0001;
    tick();
    check("ho_gnt1", gnt, 4'b0001);
    check("ho_own1", owner, 0);
    tick();
    check("ho_gnt2", gnt, 4'b0001);
    done = 4'b0001;
    tick();
    check("ho_gap", gnt, 4'b0000);
    check("ho_gap_tmo", tmo, 0);
    done = '0; req = 4'b0010; arb = 4'b0010;
    tick();
    check("ho_gnt_p1", gnt, 4'b0010);
    check("ho_own_p1", owner, 1);
    check("ho_tmo", tmo, 0);
    req = '0; arb = '0;
    tick();
    tick();

    // hold limit forces release after exactly 8 cycles
    req = 4'b1000; arb = 4'b1000;
    tick();
    for (int i = 0; i < 8; i++) begin
      check("to_hold", gnt, 4'b1000);
      tick();
    end
    check("to_gap_gnt", gnt, 4'b0000);
    check("to_pulse", tmo, 1);
    tick();
    check("to_regrant", gnt, 4'b1000);
    check("to_pulse_end", tmo, 0);
    req = '0; arb = '0;
    tick();
    check("to_drop_tmo", tmo, 0);
    tick();

    // done coincident with the limit is a normal release; non-owner done ignored
    req = 4'b0010; arb = 4'b0010; done = 4'b0001;
    tick();
    for (int i = 0; i < 7; i++) begin
      check("co_hold", gnt, 4'b0010);
      tick();
    end
    check("co_hold8", gnt, 4'b0010);
    done = 4'b0011;
    tick();
    check("co_gap", gnt, 4'b0000);
    check("co_tmo", tmo, 0);
    done = '0; req = '0; arb = '0;
    tick();
    tick();

    // non-one-hot grant keeps lowest bit; grant for a non-requester is dropped
    req = 4'b0100; arb = 4'b0010;
    tick();
    check("mask_idle", {busy, gnt}, 5'b0);
    req = 4'b0110; arb = 4'b0110;
    tick();
    check("low_gnt", gnt, 4'b0010);
    check("low_own", owner, 1);
    req = '0; arb = '0;
    tick();
    tick();

    // request drop mid-grant
    req = 4'b0001; arb = 4'b0001;
    tick();
    tick();
    check("rd_gnt", gnt, 4'b0001);
    req = '0; arb = '0;
    tick();
    check("rd_gap", {busy, gnt}, 5'b0);
    check("rd_tmo", tmo, 0);
    tick();
    check("rd_idle", busy, 0);

    // asynchronous reset between edges
    req = 4'b0001; arb = 4'b0001;
    tick();
    check("ar_pre", gnt, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("ar_gnt", gnt, 4'b0000);
    check("ar_busy", busy, 0);
    #2 rst_n = 1'b1;
    tick();
    check("ar_after", gnt, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
